mac_tx_pkt_gen: RTL and testbench

- Synthesisable Ethernet frame generator that drives the 25GE MAC TX AXI4-Stream (64-bit) in the QSFP MAC top.
- Gated by mac_ready, it sends a programmed number of frames. Each frame carries a sequence number and a deterministic payload, so the looped-back RX stream can be checked byte for byte.
- It replaces the idle-only bring-up with active traffic and sits beside the MAC in place of a test-only packet monitor.

---
 rtl/mac_tx_pkt_gen_if.sv | 13 +
 rtl/mac_tx_pkt_gen.sv | 178 +++++++++++++++++
 tb/tb_mac_tx_pkt_gen.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_pkt_gen_if.sv
// 64-bit AXI4-Stream link from the frame generator to the MAC TX port.
// Byte i of tdata is on [8i+7:8i]; byte 0 goes on the wire first.
interface mac_tx_pkt_gen_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/mac_tx_pkt_gen.sv
// Ethernet test-frame generator for the MAC TX stream: header, 32-bit sequence number, XOR payload.
// First beat one clock after SEND entry, registered outputs; beats hold while tready is low, no bubbles otherwise.
module mac_tx_pkt_gen #(
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0002_0304_0506,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int          IFG_CYCLES = 4,
  parameter int          MIN_LEN    = 60,
  parameter int          MAX_LEN    = 1514
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mac_ready,
  input  logic                    enable,
  input  logic [15:0]             num_pkts,
  input  logic [10:0]             frame_len,
  mac_tx_pkt_gen_if.master        m_axis,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             tx_pkt_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_SEND, S_GAP, S_DONE} state_t;

  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [15:0] GAP_LAST = 16'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  state_t      state_q, state_d;
  logic [10:0] len_q;
  logic [31:0] seq_q;
  logic [7:0]  idx_q;
  logic [15:0] run_cnt_q;
  logic [15:0] gap_cnt_q;
  logic [31:0] pkt_cnt_q;
  logic        tvalid_q, tlast_q;
  logic [63:0] tdata_q;
  logic [7:0]  tkeep_q;

  logic        accept, last_acc, load, run_full;
  logic [10:0] len_clamp;
  logic [31:0] seq_src;
  logic [7:0]  b_idx;
  logic [10:0] b_len;
  logic [31:0] b_seq;
  logic [63:0] b_dat;
  logic [7:0]  b_keep;
  logic        b_last;

  function automatic logic [7:0] frame_byte(input logic [10:0] k, input logic [10:0] len,
                                            input logic [31:0] seq);
    logic [143:0] hdr;
    logic [7:0]   b;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq} << {k, 3'b000};
    if (k >= len)
      b = 8'h00;
    else if (k < 11'd18)
      b = hdr[143:136];
    else
      b = k[7:0] ^ seq[7:0];
    return b;
  endfunction

  assign accept    = tvalid_q & m_axis.tready;
  assign last_acc  = accept & tlast_q;
  assign run_full  = (num_pkts != 16'd0) && ((run_cnt_q + 16'd1) == num_pkts);
  assign len_clamp = (frame_len < MIN_L) ? MIN_L : ((frame_len > MAX_L) ? MAX_L : frame_len);
  // A back-to-back frame loads in the same cycle its predecessor's tlast is counted.
  assign seq_src   = last_acc ? (pkt_cnt_q + 32'd1) : pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE:     if (enable) state_d = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (!enable)        state_d = S_IDLE;
        else if (mac_ready) state_d = S_SEND;
      end
      S_SEND: begin
        if (!tvalid_q) begin
          load = 1'b1;
        end else if (last_acc) begin
          if (run_full)                   state_d = S_DONE;
          else if (!enable || !mac_ready) state_d = S_IDLE;
          else if (IFG_CYCLES > 0)        state_d = S_GAP;
          else                            load    = 1'b1;
        end
      end
      S_GAP: begin
        // The final gap clock preloads beat 0 so exactly IFG_CYCLES idle clocks appear.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = S_SEND;
          load    = 1'b1;
        end
      end
      S_DONE:     if (!enable) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic [10:0] k;
    b_idx  = load ? 8'd0 : (idx_q + 8'd1);
    b_len  = load ? len_clamp : len_q;
    b_seq  = load ? seq_src : seq_q;
    b_dat  = '0;
    b_keep = '0;
    for (int i = 0; i < 8; i++) begin
      k                = {b_idx, 3'b000} + 11'(i);
      b_dat[8*i +: 8]  = frame_byte(k, b_len, b_seq);
      b_keep[i]        = (k < b_len);
    end
    b_last = ({1'b0, b_idx, 3'b000} + 12'd8) >= {1'b0, b_len};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      seq_q     <= '0;
      idx_q     <= '0;
      run_cnt_q <= '0;
      gap_cnt_q <= '0;
      pkt_cnt_q <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
    end else begin
      if (load) begin
        len_q <= len_clamp;
        seq_q <= seq_src;
        idx_q <= 8'd0;
      end else if (accept && !tlast_q) begin
        idx_q <= idx_q + 8'd1;
      end

      if (load || (accept && !tlast_q)) begin
        tvalid_q <= 1'b1;
        tdata_q  <= b_dat;
        tkeep_q  <= b_keep;
        tlast_q  <= b_last;
      end else if (last_acc) begin
        tvalid_q <= 1'b0;
        tdata_q  <= '0;
        tkeep_q  <= '0;
        tlast_q  <= 1'b0;
      end

      if (last_acc) pkt_cnt_q <= pkt_cnt_q + 32'd1;

      if (state_q == S_IDLE && state_d != S_IDLE) run_cnt_q <= '0;
      else if (last_acc)                            run_cnt_q <= run_cnt_q + 16'd1;

      if (state_q == S_GAP) gap_cnt_q <= gap_cnt_q + 16'd1;
      else                  gap_cnt_q <= '0;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = 1'b0;
  assign busy          = (state_q == S_WAIT_RDY) || (state_q == S_SEND) || (state_q == S_GAP);
  assign done          = (state_q == S_DONE);
  assign tx_pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_mac_tx_pkt_gen.sv
// Bench for mac_tx_pkt_gen: randomized tready/lengths against a byte-level frame model.
module tb_mac_tx_pkt_gen;
  localparam int          IFG = 4;
  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0002_0304_0506;
  localparam logic [15:0] ET  = 16'h88B5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mac_ready = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] num_pkts = '0;
  logic [10:0] frame_len = 11'd60;
  logic        busy, done;
  logic [31:0] tx_pkt_cnt;

  mac_tx_pkt_gen_if axis ();

  mac_tx_pkt_gen #(.IFG_CYCLES(IFG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mac_ready  (mac_ready),
    .enable     (enable),
    .num_pkts   (num_pkts),
    .frame_len  (frame_len),
    .m_axis     (axis),
    .busy       (busy),
    .done       (done),
    .tx_pkt_cnt (tx_pkt_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = '0;

  logic [7:0]  cap_bytes[$];
  logic [7:0]  cap_keep[$];
  logic [63:0] cap_dat[$];
  int          cap_idle, cap_stall, cap_junk;
  bit          cap_to;

  // Reference model: frame bytes straight from the layout rules.
  function automatic int ref_len(input int fl);
    return (fl < 60) ? 60 : ((fl > 1514) ? 1514 : fl);
  endfunction

  function automatic logic [7:0] ref_byte(input int k, input logic [31:0] seq);
    if (k < 6)  return 8'(DST >> (8 * (5 - k)));
    if (k < 12) return 8'(SRC >> (8 * (11 - k)));
    if (k < 14) return 8'(ET >> (8 * (13 - k)));
    if (k < 18) return 8'(seq >> (8 * (17 - k)));
    return 8'(k) ^ seq[7:0];
  endfunction

  function automatic logic [7:0] ref_last_keep(input int len);
    int r = len % 8;
    return (r == 0) ? 8'hFF : 8'((1 << r) - 1);
  endfunction

  // Counts every discrepancy between the captured frame and the model.
  function automatic int frame_errors(input int len, input logic [31:0] seq);
    int e = 0;
    int nb = (len + 7) / 8;
    if (cap_to) e++;
    if (cap_dat.size() != nb) e++;
    if (cap_bytes.size() != len) e++;
    e += cap_junk;
    for (int j = 0; j < cap_keep.size(); j++)
      if (cap_keep[j] !== ((j == nb - 1) ? ref_last_keep(len) : 8'hFF)) e++;
    for (int k = 0; k < cap_bytes.size() && k < len; k++)
      if (cap_bytes[k] !== ref_byte(k, seq)) e++;
    return e;
  endfunction

  // Captures one frame with tready at duty% probability; drop_at>0 clears enable after that many beats.
  task automatic collect_frame(input int duty, input int drop_at);
    bit          stalled = 0;
    bit          got_last = 0;
    logic [63:0] pd = '0;
    logic [7:0]  pk = '0;
    logic        pl = 1'b0;
    int          beats = 0;
    cap_bytes.delete(); cap_keep.delete(); cap_dat.delete();
    cap_idle = 0; cap_stall = 0; cap_junk = 0;
    for (int cyc = 0; cyc < 4000 && !got_last; cyc++) begin
      @(posedge clk); #1;
      axis.tready = (int'($urandom_range(99)) < duty);
      @(negedge clk);
      if (stalled && (axis.tvalid !== 1'b1 || axis.tdata !== pd || axis.tkeep !== pk || axis.tlast !== pl))
        cap_stall++;
      if (axis.tvalid !== 1'b1 && beats == 0) cap_idle++;
      stalled = (axis.tvalid === 1'b1) && (axis.tready === 1'b0);
      pd = axis.tdata; pk = axis.tkeep; pl = axis.tlast;
      if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
        cap_dat.push_back(axis.tdata);
        cap_keep.push_back(axis.tkeep);
        for (int i = 0; i < 8; i++) begin
          if (axis.tkeep[i]) cap_bytes.push_back(axis.tdata[8*i +: 8]);
          else if (axis.tdata[8*i +: 8] !== 8'h00) cap_junk++;
        end
        beats++;
        if (beats == drop_at) enable = 1'b0;
        if (axis.tlast === 1'b1) got_last = 1;
      end
    end
    cap_to = !got_last;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; mac_ready = 1'b0; axis.tready = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    axis.tready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if ({axis.tvalid, axis.tlast, axis.tuser, busy, done} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {axis.tvalid, axis.tlast, axis.tuser, busy, done});
    end
    total++;
    if ({axis.tdata, axis.tkeep} !== 72'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {axis.tdata, axis.tkeep});
    end
    total++;
    if (tx_pkt_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d want 0", tx_pkt_cnt);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_bringup();
    int viol = 0;
    bit seen = 0;
    num_pkts = 16'd1; frame_len = 11'd64; axis.tready = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk);
    repeat (50) begin
      @(negedge clk);
      if (axis.tvalid !== 1'b0 || busy !== 1'b1) viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++; $display("FAIL bringup_gate: got %0d bad cycles want 0", viol);
    end
    @(posedge clk); #1 mac_ready = 1'b1;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      if (axis.tvalid === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL bringup_tvalid: got 0 want 1 within 2 cycles");
    end
  endtask

  task automatic test_single_frame();
    logic [63:0] b0;
    logic [31:0] s;
    collect_frame(100, 0);
    b0 = (cap_dat.size() > 0) ? cap_dat[0] : 64'h0;
    s  = (cap_bytes.size() >= 19) ? {cap_bytes[14], cap_bytes[15], cap_bytes[16], cap_bytes[17]} : 32'hFFFF_FFFF;
    total++;
    if (cap_dat.size() != 8 || cap_to) begin
      bad++; $display("FAIL single_beats: got %0d want 8", cap_dat.size());
    end
    total++;
    if (b0 !== 64'h0200_FFFF_FFFF_FFFF) begin
      bad++; $display("FAIL single_beat0: got %h want 0200ffffffffffff", b0);
    end
    total++;
    if (s !== 32'h0 || cap_bytes.size() < 19 || cap_bytes[18] !== 8'h12) begin
      bad++; $display("FAIL single_seq_payload: got seq %h want 0 and byte18 12", s);
    end
    total++;
    if (frame_errors(64, 32'd0) !== 0) begin
      bad++; $display("FAIL single_content: got %0d errors want 0", frame_errors(64, 32'd0));
    end
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_pkt_cnt !== exp_cnt) begin
      bad++; $display("FAIL single_done: got done=%b busy=%b cnt=%0d want 1 0 %0d", done, busy, tx_pkt_cnt, exp_cnt);
    end
    @(posedge clk); #1 enable = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_length_edges();
    int lens[7];
    int l;
    lens[0] = 61; lens[1] = 20; lens[2] = 2000;
    for (int i = 3; i < 7; i++) lens[i] = int'($urandom_range(2047));
    for (int i = 0; i < 7; i++) begin
      l = ref_len(lens[i]);
      frame_len = 11'(lens[i]); num_pkts = 16'd1;
      @(posedge clk); #1 enable = 1'b1; mac_ready = 1'b1;
      collect_frame(100, 0);
      total++;
      if (cap_dat.size() != (l + 7) / 8) begin
        bad++; $display("FAIL len_beats[%0d]: got %0d want %0d", lens[i], cap_dat.size(), (l + 7) / 8);
      end
      total++;
      if (cap_keep.size() == 0 || cap_keep[cap_keep.size() - 1] !== ref_last_keep(l)) begin
        bad++; $display("FAIL len_last_keep[%0d]: got %h want %h", lens[i],
                        (cap_keep.size() > 0) ? cap_keep[cap_keep.size() - 1] : 8'h00, ref_last_keep(l));
      end
      total++;
      if (frame_errors(l, exp_cnt) !== 0) begin
        bad++; $display("FAIL len_content[%0d]: got %0d errors want 0", lens[i], frame_errors(l, exp_cnt));
      end
      exp_cnt = exp_cnt + 1;
      @(negedge clk);
      total++;
      if (tx_pkt_cnt !== exp_cnt) begin
        bad++; $display("FAIL len_cnt[%0d]: got %0d want %0d", lens[i], tx_pkt_cnt, exp_cnt);
      end
      @(posedge clk); #1 enable = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    num_pkts = 16'd10; frame_len = 11'd128;
    @(posedge clk); #1 enable = 1'b1; mac_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      collect_frame(30, 0);
      total++;
      if (cap_stall !== 0) begin
        bad++; $display("FAIL bp_stable[%0d]: got %0d changes want 0", f, cap_stall);
      end
      total++;
      if (frame_errors(128, 32'(f)) !== 0) begin
        bad++; $display("FAIL bp_content[%0d]: got %0d errors want 0", f, frame_errors(128, 32'(f)));
      end
    end
    exp_cnt = 32'd10;
    @(negedge clk);
    total++;
    if (tx_pkt_cnt !== 32'd10 || done !== 1'b1) begin
      bad++; $display("FAIL bp_count: got cnt=%0d done=%b want 10 1", tx_pkt_cnt, done);
    end
    @(posedge clk); #1 enable = 1'b0; axis.tready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_gap_continuous();
    int viol = 0;
    num_pkts = 16'd0; frame_len = 11'd100;
    @(posedge clk); #1 enable = 1'b1; mac_ready = 1'b1; axis.tready = 1'b1;
    collect_frame(100, 0);
    exp_cnt = exp_cnt + 1;
    for (int f = 0; f < 3; f++) begin
      collect_frame(100, (f == 2) ? 3 : 0);
      total++;
      if (cap_idle !== IFG) begin
        bad++; $display("FAIL gap_idle[%0d]: got %0d want %0d", f, cap_idle, IFG);
      end
      total++;
      if (frame_errors(100, exp_cnt) !== 0) begin
        bad++; $display("FAIL gap_content[%0d]: got %0d errors want 0", f, frame_errors(100, exp_cnt));
      end
      exp_cnt = exp_cnt + 1;
    end
    repeat (10) begin
      @(negedge clk);
      if (axis.tvalid !== 1'b0 || busy !== 1'b0) viol++;
    end
    total++;
    if (viol !== 0 || tx_pkt_cnt !== exp_cnt) begin
      bad++; $display("FAIL gap_stop: got %0d active cycles cnt=%0d want 0 %0d", viol, tx_pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0;
    bit hit = 0;
    num_pkts = 16'd0; frame_len = 11'd200; axis.tready = 1'b1;
    @(posedge clk); #1 enable = 1'b1; mac_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      if (seen == 3 && axis.tvalid === 1'b1) hit = 1;
      else if (axis.tvalid === 1'b1 && axis.tready === 1'b1) seen++;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL midrst_reach: got %0d beats want 3", seen);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({axis.tvalid, axis.tlast, axis.tkeep, axis.tdata, busy, done, tx_pkt_cnt} !== '0) begin
      bad++; $display("FAIL midrst_outputs: got tvalid=%b tdata=%h cnt=%0d want all 0", axis.tvalid, axis.tdata, tx_pkt_cnt);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
    collect_frame(100, 0);
    total++;
    if (frame_errors(200, 32'd0) !== 0) begin
      bad++; $display("FAIL midrst_seq0: got %0d errors want 0", frame_errors(200, 32'd0));
    end
    @(negedge clk);
    total++;
    if (tx_pkt_cnt !== 32'd1) begin
      bad++; $display("FAIL midrst_cnt: got %0d want 1", tx_pkt_cnt);
    end
    @(posedge clk); #1 enable = 1'b0;
  endtask

  initial begin
    axis.tready = 1'b0;
    test_reset();
    test_bringup();
    test_single_frame();
    test_length_edges();
    test_backpressure();
    test_gap_continuous();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
